alu_mdu_param: RTL and testbench
================================

Name: alu_mdu_param

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU in the MIPS datapath.
- Keeps the existing 4-bit op encoding and adds SRA, signed overflow, and an iterative unsigned multiply/divide unit with HI/LO outputs.
- Registers every result and exposes valid/ready on both sides, so the execute stage can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- SHW, $clog2(WIDTH), shamt width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an op this cycle.
- op  in  4  operation code.
- first  in  WIDTH  operand A (shift source for sll/srl/sra).
- second  in  WIDTH  operand B.
- shamt  in  SHW  shift amount.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result (LO for mul/div).
- hi  out  WIDTH  HI for mul (upper product) / div (remainder); 0 otherwise.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for add/sub; 0 otherwise.

Behaviour:
- Reset is synchronous, active-high; only one clock. On reset: state=IDLE; out_valid=0; result=0; hi=0; zero=1; overflow=0; in_ready=1 from the cycle after reset deasserts.
- Reset mid-operation aborts the op; no result is produced.
- Op codes:
  - Single-cycle: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (signed: 1 if first<second), 1100 nor, 1101 sll, 1110 srl, 1111 sra (first >>> shamt).
  - Multi-cycle: 1000 multu, 1001 divu.
  - Any other code: result=0, hi=0, completes as single-cycle.
- Accept: when in_valid && in_ready, the op is captured on that clk edge.
- FSM states and transitions:
  - IDLE: in_ready=1. Single-cycle op: result is registered on the accept edge, go to DONE, out_valid=1 on the next cycle (latency 1). mul/div: load operands, count=WIDTH, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. One shift-add (multu) or restoring-subtract (divu) step per cycle; count decrements. At count==1 the final step writes result/hi and goes to DONE. Accept-to-out_valid latency is WIDTH+1 cycles (33 for WIDTH=32).
  - DONE: out_valid=1; result/hi/zero/overflow held stable until out_ready.
    - out_ready=1 and no new accept: go to IDLE, out_valid=0.
    - in_ready = out_ready in DONE. A simultaneous retire and new accept is legal: a single-cycle op stays in DONE with the new result (back-to-back throughput 1/cycle); mul/div goes to BUSY.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - overflow = operand signs equal (add) or differ (sub) and result sign differs from first's sign.
  - slt uses a signed compare, not the sub sign bit, so it is correct on overflow.
  - Shifts use shamt only; second is ignored.
  - multu: {hi,result} = full 2*WIDTH unsigned product.
  - divu: result=quotient, hi=remainder.
  - divu by zero: result=all-ones, hi=first, same latency, overflow=0.
- zero is computed from result only, never from hi.

Optional Feature:
- ALU_SIGNED_MD_EN defined: adds op 1010 mult (signed) and 1011 div (signed). Operands are converted to magnitudes, the unsigned iteration is reused, then signs are fixed in one extra cycle (latency WIDTH+2).
  - Quotient truncates toward zero; remainder takes the sign of first.
  - div by zero: result=all-ones, hi=first.
  - Most-negative / -1: result=most-negative, hi=0, overflow=1.
- ALU_SIGNED_MD_EN undefined: 1010/1011 are unknown ops (result=0, single-cycle).

Decomposition:
- Shared package alu_pkg:
  - op-code localparams (OP_AND … OP_DIV);
  - FSM state enum (IDLE, BUSY, FIXUP, DONE);
  - helper function for signed-overflow detection.
- Natural sub-module: alu_md_iter, holding the iterative multiply/divide datapath and counter. Interface: start/done, WIDTH parameter. The top module holds the handshake FSM and single-cycle ALU.

Test Plan:
- Reset, then add 5+17 with out_ready=1 -> out_valid one cycle after accept; result=22, zero=0, overflow=0.
- sub 0x7FFFFFFF - 0xFFFFFFFF -> result=0x80000000, overflow=1; slt 15,16 -> result=1; slt 95,65 -> result=0.
- sra first=0x80000055 shamt=3 -> 0xF000000A; srl same -> 0x1000000A; sll 657 by 8 -> 0x29100.
- multu 0xFFFFFFFF*0xFFFFFFFF -> result=0x00000001, hi=0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout BUSY.
- divu 450/95 -> result=4, hi=70. divu 7/0 -> result=0xFFFFFFFF, hi=7. Assert reset at BUSY cycle 10 -> out_valid stays 0 and in_ready=1 the cycle after reset deasserts.
- Backpressure: hold out_ready=0 for 5 cycles after an and 97&97 -> result=97 stable, in_ready=0. Then out_ready=1 with a new or 42|33 presented -> next cycle result=43, out_valid continuously 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, handshake FSM states and the signed-overflow helper
// for the alu_mdu_param execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLL   = 4'b1101;
    localparam logic [3:0] OP_SRL   = 4'b1110;
    localparam logic [3:0] OP_SRA   = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    // Works on sign bits only, so it is independent of WIDTH.
    function automatic logic signed_ovf(input logic sa, input logic sb,
                                        input logic sr, input logic is_sub);
        if (is_sub)
            return (sa != sb) && (sr != sa);
        else
            return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// lo/hi present the post-step values; done flags that this step is the last.
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] lo_q, hi_q, b_q, lo_n, hi_n;
    logic             div_q;
    logic [WIDTH:0]   sum, shifted;

    // Divide by zero falls out naturally: every trial succeeds (quotient all
    // ones) and the remainder register ends up holding the dividend.
    always_comb begin
        lo_n    = lo_q;
        hi_n    = hi_q;
        sum     = '0;
        shifted = '0;
        if (div_q) begin
            shifted = {hi_q, lo_q[WIDTH-1]};
            if (shifted >= {1'b0, b_q}) begin
                hi_n = WIDTH'(shifted - {1'b0, b_q});
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = (count == CW'(1));
    assign lo   = lo_n;
    assign hi   = hi_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            count <= CW'(WIDTH);
            lo_q  <= a;
            hi_q  <= '0;
            b_q   <= b;
            div_q <= is_div;
        end else if (count != '0) begin
            count <= count - CW'(1);
            lo_q  <= lo_n;
            hi_q  <= hi_n;
        end
    end

endmodule

// File: rtl/alu_mdu_param.sv
// Handshaked, registered MIPS ALU with iterative multiply/divide (HI/LO).
// Define ALU_SIGNED_MD_EN to add signed mult/div (ops 1010/1011).
module alu_mdu_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow
);

    state_t           state, state_n;
    logic             accept, is_md, md_div, md_done, fix_pending, alu_ovf;
    logic [WIDTH-1:0] alu_res, sum, diff, md_a, md_b, md_lo, md_hi;

`ifdef ALU_SIGNED_MD_EN
    logic             sgn_q, sdiv_q, neg_a_q, neg_b_q, bz_q, ovf_case_q;
    logic [WIDTH-1:0] first_q;
    assign fix_pending = sgn_q;
`else
    assign fix_pending = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign zero      = (result == '0);

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        sum     = first + second;
        diff    = first - second;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = first & second;
            OP_OR:  alu_res = first | second;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = signed_ovf(first[WIDTH-1], second[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = signed_ovf(first[WIDTH-1], second[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(first) < $signed(second))};
            OP_NOR: alu_res = ~(first | second);
            OP_SLL: alu_res = first << shamt;
            OP_SRL: alu_res = first >> shamt;
            OP_SRA: alu_res = $signed(first) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Signed ops feed magnitudes to the unsigned iterator; signs are fixed in FIXUP.
    always_comb begin
        is_md  = (op == OP_MULTU) || (op == OP_DIVU);
        md_div = (op == OP_DIVU);
        md_a   = first;
        md_b   = second;
`ifdef ALU_SIGNED_MD_EN
        if (op == OP_MULT || op == OP_DIV) begin
            is_md  = 1'b1;
            md_div = (op == OP_DIV);
            md_a   = first[WIDTH-1]  ? -first  : first;
            md_b   = second[WIDTH-1] ? -second : second;
        end
`endif
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_md),
        .is_div (md_div),
        .a      (md_a),
        .b      (md_b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = is_md ? BUSY : DONE;
            BUSY:  if (md_done) state_n = fix_pending ? FIXUP : DONE;
            FIXUP: state_n = DONE;
            DONE: begin
                if (accept)         state_n = is_md ? BUSY : DONE;
                else if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            hi       <= '0;
            overflow <= 1'b0;
`ifdef ALU_SIGNED_MD_EN
            sgn_q      <= 1'b0;
            sdiv_q     <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            bz_q       <= 1'b0;
            ovf_case_q <= 1'b0;
            first_q    <= '0;
`endif
        end else begin
            if (accept) begin
                if (is_md) begin
                    overflow <= 1'b0;
                end else begin
                    result   <= alu_res;
                    hi       <= '0;
                    overflow <= alu_ovf;
                end
`ifdef ALU_SIGNED_MD_EN
                sgn_q      <= (op == OP_MULT) || (op == OP_DIV);
                sdiv_q     <= (op == OP_DIV);
                neg_a_q    <= first[WIDTH-1];
                neg_b_q    <= second[WIDTH-1];
                bz_q       <= (second == '0);
                ovf_case_q <= (first == {1'b1, {(WIDTH-1){1'b0}}}) && (second == '1);
                first_q    <= first;
`endif
            end else if (state == BUSY && md_done) begin
                result <= md_lo;
                hi     <= md_hi;
            end
`ifdef ALU_SIGNED_MD_EN
            // MIN / -1 already yields quotient MIN, remainder 0 from magnitudes.
            else if (state == FIXUP) begin
                if (sdiv_q) begin
                    if (bz_q) begin
                        result <= '1;
                        hi     <= first_q;
                    end else if (ovf_case_q) begin
                        overflow <= 1'b1;
                    end else begin
                        if (neg_a_q ^ neg_b_q) result <= -result;
                        if (neg_a_q)           hi     <= -hi;
                    end
                end else if (neg_a_q ^ neg_b_q) begin
                    {hi, result} <= -{hi, result};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_mdu_param.sv
// Self-checking bench for alu_mdu_param: directed table, random vectors
// against an arithmetic reference model, and handshake/reset sequences.
module tb_alu_mdu_param;

    localparam int W = 32;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, zero, overflow;
    logic [3:0]   op;
    logic [W-1:0] first, second, result, hi;
    logic [4:0]   shamt;

    int n_vec = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mdu_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .first     (first),
        .second    (second),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W-1:0] r, h;
        logic         ov;
        int           lat;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic ov, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.sh = sh; v.r = r; v.h = h; v.ov = ov; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide signed/unsigned arithmetic.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] sh, output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic ov, output int lat);
        longint sa, sb, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; h = '0; ov = 1'b0; lat = 1;
        case (o)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin t = sa + sb; p = t; r = p[31:0]; ov = (t > SMAX) || (t < SMIN); end
            4'd6:  begin t = sa - sb; p = t; r = p[31:0]; ov = (t > SMAX) || (t < SMIN); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            4'd13: r = a << sh;
            4'd14: r = a >> sh;
            4'd15: begin t = sa >>> sh; p = t; r = p[31:0]; end
            4'd8:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; h = p[63:32]; lat = W + 1; end
            4'd9:  begin
                lat = W + 1;
                if (b == 0) begin r = '1; h = a; end
                else begin r = a / b; h = a % b; end
            end
`ifdef ALU_SIGNED_MD_EN
            4'd10: begin t = sa * sb; p = t; r = p[31:0]; h = p[63:32]; lat = W + 2; end
            4'd11: begin
                lat = W + 2;
                if (b == 0) begin r = '1; h = a; end
                else if (sa == SMIN && sb == -1) begin r = 32'h80000000; h = '0; ov = 1'b1; end
                else begin
                    t = sa / sb; p = t; r = p[31:0];
                    t = sa % sb; p = t; h = p[31:0];
                end
            end
`endif
            default: ;
        endcase
    endfunction

    task automatic apply(input vec_t v, input string tag);
        int   lat;
        logic ir_bad;
        @(negedge clk);
        op = v.op; first = v.a; second = v.b; shamt = v.sh;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; ir_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        check({tag, " result"},   result,   v.r);
        check({tag, " hi"},       hi,       v.h);
        check({tag, " zero"},     zero,     (v.r == 0));
        check({tag, " overflow"}, overflow, v.ov);
        check({tag, " latency"},  lat,      v.lat);
        if (v.lat > 1) check({tag, " in_ready_busy"}, ir_bad, 1'b0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " retire"}, out_valid, 1'b0);
        @(negedge clk); out_ready = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        logic [W-1:0] ra, rb, rr, rh;
        logic [3:0]   ro;
        logic [4:0]   rs;
        logic         rov, ov_seen;
        int           rlat;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; first = '0; second = '0; shamt = '0;

        tbl.push_back(mk(4'b0010, 32'd5,        32'd17,       5'd0, 32'd22,       32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'd0,        1'b1, 1));
        tbl.push_back(mk(4'b0111, 32'd15,       32'd16,       5'd0, 32'd1,        32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b0111, 32'd95,       32'd65,       5'd0, 32'd0,        32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b1111, 32'h80000055, 32'd0,        5'd3, 32'hF000000A, 32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b1110, 32'h80000055, 32'd0,        5'd3, 32'h1000000A, 32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b1101, 32'd657,      32'hFFFF,     5'd8, 32'h00029100, 32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33));
        tbl.push_back(mk(4'b1001, 32'd450,      32'd95,       5'd0, 32'd4,        32'd70,       1'b0, 33));
        tbl.push_back(mk(4'b1001, 32'd7,        32'd0,        5'd0, 32'hFFFFFFFF, 32'd7,        1'b0, 33));
        tbl.push_back(mk(4'b0010, 32'h7FFFFFFF, 32'd1,        5'd0, 32'h80000000, 32'd0,        1'b1, 1));
        tbl.push_back(mk(4'b0010, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,        32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b0111, 32'h80000000, 32'd1,        5'd0, 32'd1,        32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b0110, 32'h80000000, 32'd1,        5'd0, 32'h7FFFFFFF, 32'd0,        1'b1, 1));
        tbl.push_back(mk(4'b1100, 32'd0,        32'd0,        5'd0, 32'hFFFFFFFF, 32'd0,        1'b0, 1));
        tbl.push_back(mk(4'b0011, 32'd5,        32'd6,        5'd0, 32'd0,        32'd0,        1'b0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        check("rst out_valid", out_valid, 1'b0);
        check("rst result",    result,    32'd0);
        check("rst hi",        hi,        32'd0);
        check("rst zero",      zero,      1'b1);
        check("rst overflow",  overflow,  1'b0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst in_ready", in_ready, 1'b1);

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset during BUSY aborts the multiply.
        @(negedge clk);
        op = 4'b1000; first = 32'd1234; second = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        check("abort in_ready", in_ready, 1'b1);
        ov_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort out_valid", ov_seen, 1'b0);

        // Backpressure, then retire with a simultaneous new accept.
        @(negedge clk);
        op = 4'b0000; first = 32'd97; second = 32'd97; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        n_vec++;
        for (int k = 0; k < 5; k++) begin
            check("bp out_valid", out_valid, 1'b1);
            check("bp result",    result,    32'd97);
            check("bp in_ready",  in_ready,  1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        op = 4'b0001; first = 32'd42; second = 32'd33; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        check("b2b out_valid", out_valid, 1'b1);
        check("b2b result",    result,    32'd43);
        @(posedge clk); #1;
        check("b2b retire", out_valid, 1'b0);
        @(negedge clk); out_ready = 1'b0;

        // Random vectors against the reference model.
        for (int k = 0; k < 60; k++) begin
            ro = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: ra = 32'd0;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            rs = 5'($urandom_range(0, 31));
            model(ro, ra, rb, rs, rr, rh, rov, rlat);
            apply(mk(ro, ra, rb, rs, rr, rh, rov, rlat), $sformatf("rnd%0d op%0h", k, ro));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
